// File: rtl/matmul_result_streamer_if.sv
// Handshake bundle between the matrix multiplier, the result streamer and the downstream sink.
// The slave side is the streamer; the master side is whatever drives done/c_flat/out_ready.
interface matmul_result_streamer_if #(
    parameter int N = 4,
    parameter int W = 16
);
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;

    logic                done;
    logic [N*N*W-1:0]    c_flat;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [RW-1:0]       out_row;
    logic [RW-1:0]       out_col;
    logic                out_last;
    logic                busy;
    logic                overrun;
    logic [7:0]          frame_cnt;

    modport master (
        output done, c_flat, out_ready,
        input  out_valid, out_data, out_row, out_col, out_last, busy, overrun, frame_cnt
    );

    modport slave (
        input  done, c_flat, out_ready,
        output out_valid, out_data, out_row, out_col, out_last, busy, overrun, frame_cnt
    );
endinterface

// File: rtl/matmul_result_streamer.sv
// Captures an NxN result matrix on a done pulse and streams it out element by element in
// row-major order over a valid/ready handshake; counts frames and flags dropped done pulses.
module matmul_result_streamer #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matmul_result_streamer_if.slave  bus
);
    localparam int unsigned NE = N * N;
    localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int unsigned RW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW = NE * W;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      frame_q, frame_d;
    logic            ovr_q, ovr_d;
    logic [BW-1:0]   mat_q;
    logic [BW-1:0]   src_c;
    logic            load_c, xfer_c, at_last_c;

    logic            valid_q, busy_q, last_q, last_d;
    logic [W-1:0]    data_q, data_d;
    logic [RW-1:0]   row_q, row_d, col_q, col_d;

    // Next state, index, counters and the registered view of the next element.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        ovr_d     = ovr_q;
        load_c    = 1'b0;
        at_last_c = (idx_q == IW'(NE - 1));
        xfer_c    = (state_q == STREAM) && bus.out_ready;

        case (state_q)
            IDLE: begin
                if (bus.done) begin
                    load_c  = 1'b1;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer_c && at_last_c) begin
                    frame_d = frame_q + 8'd1;
                    idx_d   = '0;
                    // A done coinciding with the final transfer chains straight into the next frame.
                    if (bus.done) begin
                        load_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer_c) begin
                        idx_d = idx_q + IW'(1);
                    end
                    if (bus.done) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        src_c  = load_c ? bus.c_flat : mat_q;
        data_d = (state_d == STREAM) ? src_c[int'(idx_d) * W +: W] : '0;
        row_d  = RW'(int'(idx_d) / N);
        col_d  = RW'(int'(idx_d) % N);
        last_d = (state_d == STREAM) && (idx_d == IW'(NE - 1));
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            frame_q <= '0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            ovr_q   <= ovr_d;
            valid_q <= (state_d == STREAM);
            busy_q  <= (state_d == STREAM);
            last_q  <= last_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Matrix buffer only changes on an accepted capture; reset leaves it alone.
    always_ff @(posedge clk) begin
        if (load_c) begin
            mat_q <= bus.c_flat;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.out_last  = last_q;
    assign bus.out_data  = data_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_cnt = frame_q;
endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench: a queue of expected beats is filled whenever a done pulse should be
// accepted, and a negedge monitor compares every presented element against the queue head.
module tb_matmul_result_streamer;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int NE = N * N;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_result_streamer_if #(.N(N), .W(W)) bus ();
    matmul_result_streamer #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [W-1:0] d;
        int           r;
        int           c;
        bit           last;
    } beat_t;

    beat_t      q[$];
    logic [7:0] exp_frames   = 8'd0;
    int         total_frames = 0;
    bit         exp_ovr      = 1'b0;
    bit         fresh        = 1'b1;
    int         compared     = 0;
    int         mismatched   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a list of NE beats; a done is taken only if nothing is left to send.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            exp_frames = 8'd0;
            exp_ovr    = 1'b0;
            fresh      = 1'b1;
        end else begin
            if (q.size() > 0 && bus.out_ready) begin
                if (q[0].last) begin
                    exp_frames++;
                    total_frames++;
                end
                void'(q.pop_front());
            end
            if (bus.done) begin
                if (q.size() == 0) begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < N; j++) begin
                            beat_t b;
                            b.d    = bus.c_flat[(i*N+j)*W +: W];
                            b.r    = i;
                            b.c    = j;
                            b.last = (i == N-1) && (j == N-1);
                            q.push_back(b);
                        end
                    end
                    fresh = 1'b0;
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
    end

    // Monitor: outputs are compared away from the active edge.
    always @(negedge clk) begin
        chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        chk("busy",      32'(bus.busy),      32'(q.size() > 0));
        chk("overrun",   32'(bus.overrun),   32'(exp_ovr));
        chk("frame_cnt", 32'(bus.frame_cnt), 32'(exp_frames));
        if (q.size() > 0) begin
            chk("out_data", 32'(bus.out_data), 32'(q[0].d));
            chk("out_row",  32'(bus.out_row),  32'(q[0].r));
            chk("out_col",  32'(bus.out_col),  32'(q[0].c));
            chk("out_last", 32'(bus.out_last), 32'(q[0].last));
        end else begin
            chk("out_last_idle", 32'(bus.out_last), 32'd0);
            if (fresh) chk("out_data_idle", 32'(bus.out_data), 32'd0);
        end
    end

    function automatic logic [NE*W-1:0] mk(input int kind);
        logic [NE*W-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    0:       m[(i*N+j)*W +: W] = (i == j) ? W'(2) : W'(0);
                    1:       m[(i*N+j)*W +: W] = W'(16*i + j);
                    2:       m[(i*N+j)*W +: W] = W'(16'h00FF);
                    default: m[(i*N+j)*W +: W] = W'($urandom);
                endcase
            end
        end
        return m;
    endfunction

    function automatic bit rdy(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic step(input bit d, input bit r);
        @(negedge clk);
        bus.done      = d;
        bus.out_ready = r;
    endtask

    task automatic load(input logic [NE*W-1:0] m, input bit r);
        @(negedge clk);
        bus.c_flat    = m;
        bus.done      = 1'b1;
        bus.out_ready = r;
    endtask

    task automatic drain(input int mode, input int maxc, output int cyc);
        cyc = 0;
        do begin
            step(1'b0, rdy(mode, cyc));
            cyc++;
        end while (q.size() > 0 && cyc < maxc);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Run with ready=1, pulsing done with matrix m once the model has sz beats left.
    task automatic done_at(input int sz, input logic [NE*W-1:0] m, input int maxc);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < maxc && !hit; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (q.size() == sz) begin
                bus.c_flat = m;
                bus.done   = 1'b1;
                hit        = 1'b1;
            end else begin
                bus.done = 1'b0;
            end
        end
        chk("done_at_timeout", 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        bus.done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cyc;
        int loads;
        int base;
        bus.done      = 1'b0;
        bus.out_ready = 1'b0;
        bus.c_flat    = '0;
        repeat (3) @(negedge clk);
        chk("reset_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_data",  32'(bus.out_data),  32'd0);
        rst_n = 1'b1;

        // Diagonal matrix, ready always high.
        load(mk(0), 1'b1);
        drain(0, 100, cyc);
        chk("diag_cycles", 32'(cyc), 32'(NE + 1));
        chk("diag_frames", 32'(bus.frame_cnt), 32'd1);
        chk("diag_valid_after", 32'(bus.out_valid), 32'd0);

        // Index-pattern matrix with ready toggling 1,0,0,1.
        load(mk(1), 1'b1);
        drain(1, 200, cyc);
        chk("stall_frames", 32'(bus.frame_cnt), 32'd2);

        // Back-to-back frames: second done on the last transfer edge.
        do_reset();
        load(mk(0), 1'b1);
        done_at(1, mk(2), 100);
        drain(0, 100, cyc);
        chk("b2b_frames",  32'(bus.frame_cnt), 32'd2);
        chk("b2b_overrun", 32'(bus.overrun),   32'd0);

        // Done at beat 5 is dropped and flags overrun.
        do_reset();
        load(mk(3), 1'b1);
        done_at(NE - 4, mk(2), 100);
        drain(0, 100, cyc);
        chk("ovr_set", 32'(bus.overrun), 32'd1);
        repeat (5) step(1'b0, 1'b1);
        chk("ovr_sticky", 32'(bus.overrun), 32'd1);

        // Asynchronous reset mid-cycle at beat 9.
        load(mk(3), 1'b1);
        for (int c = 0; c < 50 && q.size() != NE - 8; c++) step(1'b0, 1'b1);
        chk("beat9_reached", 32'(q.size()), 32'(NE - 8));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy",  32'(bus.busy),      32'd0);
        chk("arst_last",  32'(bus.out_last),  32'd0);
        chk("arst_ovr",   32'(bus.overrun),   32'd0);
        chk("arst_frame", 32'(bus.frame_cnt), 32'd0);
        chk("arst_data",  32'(bus.out_data),  32'd0);
        chk("arst_row",   32'(bus.out_row),   32'd0);
        chk("arst_col",   32'(bus.out_col),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        load(mk(1), 1'b1);
        drain(0, 100, cyc);
        chk("arst_refill_frames", 32'(bus.frame_cnt), 32'd1);

        // Random traffic: random ready, random done pulses, random matrices.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.done      = ($urandom_range(0, 9) == 0);
            bus.c_flat    = mk(3);
        end
        drain(2, 400, cyc);

        // 256 back-to-back frames wrap frame_cnt to zero.
        do_reset();
        loads = 0;
        base  = total_frames;
        for (int c = 0; c < 256 * NE + 100 && (total_frames - base) < 256; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (loads < 256 && q.size() <= 1) begin
                bus.c_flat = mk(3);
                bus.done   = 1'b1;
                loads++;
            end else begin
                bus.done = 1'b0;
            end
        end
        step(1'b0, 1'b1);
        chk("wrap_total", 32'(total_frames - base), 32'd256);
        chk("wrap_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("wrap_overrun", 32'(bus.overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
